video_dither: RTL and testbench

- Sits directly downstream of the RTG/native video mux. Consumes its registered 8-bit RGB, pixel strobe and DE.
- Reduces each channel to OUT_BITS for the board VGA DAC, using a 4x4 ordered (Bayer) dither with optional temporal rotation.
- Delays hsync, vsync and DE so they stay aligned with the dithered colour.
- Runs entirely in the video clock domain.

---
 rtl/video_dither_if.sv | 35 +++
 rtl/video_dither.sv | 167 ++++++++++++++++
 tb/tb_video_dither.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/video_dither_if.sv
// ---------------------------------------------------------------------------
// video_dither_if
// Video stream bundle between the RTG/native video mux and the dither stage.
//   master : upstream side   - drives pixel/de_in/hs_in/vs_in/r_in/g_in/b_in,
//                              receives r_out/g_out/b_out/de_out/hs_out/vs_out
//   slave  : dither side     - the reverse directions
// OUT_BITS sets the width of the dithered colour outputs.
// ---------------------------------------------------------------------------
interface video_dither_if #(
    parameter int OUT_BITS = 6
);
    logic                pixel;
    logic                de_in;
    logic                hs_in;
    logic                vs_in;
    logic [7:0]          r_in;
    logic [7:0]          g_in;
    logic [7:0]          b_in;
    logic [OUT_BITS-1:0] r_out;
    logic [OUT_BITS-1:0] g_out;
    logic [OUT_BITS-1:0] b_out;
    logic                de_out;
    logic                hs_out;
    logic                vs_out;

    modport master (
        output pixel, de_in, hs_in, vs_in, r_in, g_in, b_in,
        input  r_out, g_out, b_out, de_out, hs_out, vs_out
    );

    modport slave (
        input  pixel, de_in, hs_in, vs_in, r_in, g_in, b_in,
        output r_out, g_out, b_out, de_out, hs_out, vs_out
    );
endinterface

// File: rtl/video_dither.sv
// ---------------------------------------------------------------------------
// video_dither
// Reduces 8-bit RGB to OUT_BITS per channel for the VGA DAC using a 4x4
// ordered (Bayer) dither, optionally rotated per frame. Sync and DE are
// delayed so they stay aligned with the colour (2-clock latency throughout).
// Ports:
//   clk          video clock, rising edge
//   reset_n      asynchronous active-low reset
//   dither_ena   1 = ordered dither, 0 = plain truncation
//   temporal_ena 1 = rotate matrix index by frame counter
//   use_strobe   1 = x advances only on pixel strobe, 0 = every DE cycle
//   vid          video stream (slave): colour/strobe/sync in, dithered out
// ---------------------------------------------------------------------------
module video_dither #(
    parameter int OUT_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 dither_ena,
    input  logic                 temporal_ena,
    input  logic                 use_strobe,
    video_dither_if.slave        vid
);
    localparam int D     = 8 - OUT_BITS;
    localparam int SHIFT = 4 - D;

    // Position / frame counters and edge-detect history
    logic [1:0] r_x;
    logic [1:0] r_y;
    logic [1:0] r_frame;
    logic       r_de_d;
    logic       r_vs_d;

    // Stage 1
    logic [7:0] r_r1, r_g1, r_b1;
    logic [3:0] r_t1;
    logic       r_de1, r_hs1, r_vs1;

    // Stage 2 (outputs)
    logic [OUT_BITS-1:0] r_r2, r_g2, r_b2;
    logic                r_de2, r_hs2, r_vs2;

    logic       w_de_fall;
    logic       w_vs_rise;
    logic [1:0] w_ix;
    logic [1:0] w_iy;
    logic [3:0] w_bayer;
    logic [3:0] w_t;
    logic [8:0] w_sum_r, w_sum_g, w_sum_b;

    assign w_de_fall = r_de_d & ~vid.de_in;
    assign w_vs_rise = vid.vs_in & ~r_vs_d;

    // Temporal rotation offsets y by the bit-reversed frame count so the
    // four frames visit distinct rows as well as columns.
    assign w_ix = r_x + (temporal_ena ? r_frame : 2'd0);
    assign w_iy = r_y + (temporal_ena ? {r_frame[0], r_frame[1]} : 2'd0);

    always_comb begin
        w_bayer = '0;
        case ({w_iy, w_ix})
            4'h0: w_bayer = 4'd0;
            4'h1: w_bayer = 4'd8;
            4'h2: w_bayer = 4'd2;
            4'h3: w_bayer = 4'd10;
            4'h4: w_bayer = 4'd12;
            4'h5: w_bayer = 4'd4;
            4'h6: w_bayer = 4'd14;
            4'h7: w_bayer = 4'd6;
            4'h8: w_bayer = 4'd3;
            4'h9: w_bayer = 4'd11;
            4'hA: w_bayer = 4'd1;
            4'hB: w_bayer = 4'd9;
            4'hC: w_bayer = 4'd15;
            4'hD: w_bayer = 4'd7;
            4'hE: w_bayer = 4'd13;
            4'hF: w_bayer = 4'd5;
            default: w_bayer = '0;
        endcase
    end

    // Threshold scaled to the number of dropped bits
    assign w_t = w_bayer >> SHIFT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_frame <= '0;
            r_de_d  <= 1'b0;
            r_vs_d  <= 1'b0;
        end else begin
            r_de_d <= vid.de_in;
            r_vs_d <= vid.vs_in;

            if (!vid.de_in)
                r_x <= '0;
            else if (vid.pixel || !use_strobe)
                r_x <= r_x + 2'd1;

            // Frame start clear takes priority over the line increment
            if (w_vs_rise)
                r_y <= '0;
            else if (w_de_fall)
                r_y <= r_y + 2'd1;

            if (w_vs_rise)
                r_frame <= r_frame + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_r1  <= '0;
            r_g1  <= '0;
            r_b1  <= '0;
            r_t1  <= '0;
            r_de1 <= 1'b0;
            r_hs1 <= 1'b0;
            r_vs1 <= 1'b0;
        end else begin
            r_r1  <= vid.r_in;
            r_g1  <= vid.g_in;
            r_b1  <= vid.b_in;
            // Blanking colour passes through; only the threshold is dropped
            r_t1  <= (dither_ena && vid.de_in) ? w_t : 4'd0;
            r_de1 <= vid.de_in;
            r_hs1 <= vid.hs_in;
            r_vs1 <= vid.vs_in;
        end
    end

    assign w_sum_r = {1'b0, r_r1} + {5'b0, r_t1};
    assign w_sum_g = {1'b0, r_g1} + {5'b0, r_t1};
    assign w_sum_b = {1'b0, r_b1} + {5'b0, r_t1};

    // Carry out of the add saturates instead of wrapping to a low code
    function automatic logic [OUT_BITS-1:0] f_sat(input logic [8:0] s);
        f_sat = s[8] ? '1 : s[7:D];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_r2  <= '0;
            r_g2  <= '0;
            r_b2  <= '0;
            r_de2 <= 1'b0;
            r_hs2 <= 1'b0;
            r_vs2 <= 1'b0;
        end else begin
            r_r2  <= f_sat(w_sum_r);
            r_g2  <= f_sat(w_sum_g);
            r_b2  <= f_sat(w_sum_b);
            r_de2 <= r_de1;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
        end
    end

    assign vid.r_out  = r_r2;
    assign vid.g_out  = r_g2;
    assign vid.b_out  = r_b2;
    assign vid.de_out = r_de2;
    assign vid.hs_out = r_hs2;
    assign vid.vs_out = r_vs2;

endmodule

// File: tb/tb_video_dither.sv
// ---------------------------------------------------------------------------
// tb_video_dither
// Drives two instances (OUT_BITS=6 and OUT_BITS=4) with identical stimulus
// and compares every cycle against a behavioural reference of the dither.
// ---------------------------------------------------------------------------
module tb_video_dither;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b1;
    logic       dith, temp, ustr;
    logic       pixel, de, hs, vs;
    logic [7:0] r, g, b;

    video_dither_if #(.OUT_BITS(6)) vif6();
    video_dither_if #(.OUT_BITS(4)) vif4();

    assign vif6.pixel = pixel;
    assign vif6.de_in = de;
    assign vif6.hs_in = hs;
    assign vif6.vs_in = vs;
    assign vif6.r_in  = r;
    assign vif6.g_in  = g;
    assign vif6.b_in  = b;
    assign vif4.pixel = pixel;
    assign vif4.de_in = de;
    assign vif4.hs_in = hs;
    assign vif4.vs_in = vs;
    assign vif4.r_in  = r;
    assign vif4.g_in  = g;
    assign vif4.b_in  = b;

    video_dither #(.OUT_BITS(6)) dut6 (
        .clk(clk), .reset_n(reset_n), .dither_ena(dith),
        .temporal_ena(temp), .use_strobe(ustr), .vid(vif6)
    );
    video_dither #(.OUT_BITS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .dither_ena(dith),
        .temporal_ena(temp), .use_strobe(ustr), .vid(vif4)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference state: position, line, frame and previous de/vs
    int   mx, my, mf;
    logic mpde, mpvs;
    logic [23:0] prev6, prev4, next6, next4;

    int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6},
                         '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    function automatic int chan(int c, int t, int ob);
        int s;
        s = c + t;
        if (s > 255) return (1 << ob) - 1;
        return s >> (8 - ob);
    endfunction

    function automatic logic [23:0] pack(int ob, int t);
        int v;
        v = (chan(int'(r), t, ob) << (2 * ob + 3)) |
            (chan(int'(g), t, ob) << (ob + 3)) |
            (chan(int'(b), t, ob) << 3) |
            int'({de, hs, vs});
        return 24'(v);
    endfunction

    task automatic chk(input string tag, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        assert (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mf = 0;
        mpde = 1'b0; mpvs = 1'b0;
        prev6 = '0; prev4 = '0;
    endtask

    // Evaluated at the clock edge with the inputs the DUT samples there
    task automatic model_edge();
        int  ix, iy, bv, t6, t4;
        logic vsr, def;
        ix = (mx + (temp ? mf : 0)) % 4;
        iy = (my + (temp ? ((mf % 2) * 2 + mf / 2) : 0)) % 4;
        bv = bayer[iy][ix];
        t6 = (dith && de) ? (bv >> 2) : 0;
        t4 = (dith && de) ? bv : 0;
        next6 = pack(6, t6);
        next4 = pack(4, t4);
        vsr = vs && !mpvs;
        def = mpde && !de;
        if (!de) mx = 0;
        else if (pixel || !ustr) mx = (mx + 1) % 4;
        if (vsr) begin
            my = 0;
            mf = (mf + 1) % 4;
        end else if (def) begin
            my = (my + 1) % 4;
        end
        mpde = de;
        mpvs = vs;
    endtask

    function automatic logic [23:0] act6();
        return {3'b0, vif6.r_out, vif6.g_out, vif6.b_out, vif6.de_out, vif6.hs_out, vif6.vs_out};
    endfunction

    function automatic logic [23:0] act4();
        return {9'b0, vif4.r_out, vif4.g_out, vif4.b_out, vif4.de_out, vif4.hs_out, vif4.vs_out};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("out6", act6(), prev6);
        chk("out4", act4(), prev4);
        prev6 = next6;
        prev4 = next4;
    endtask

    // Called #1 after an edge; asserts reset mid-cycle, releases #1 after the next edge
    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        chk("rst_async6", act6(), 24'h0);
        chk("rst_async4", act4(), 24'h0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold6", act6(), 24'h0);
        hs = 1'b0;
        vs = 1'b0;
        reset_n = 1'b1;
    endtask

    logic [5:0] gexp [8];

    initial begin
        gexp = '{6'h10, 6'h10, 6'h10, 6'h10, 6'h10, 6'h11, 6'h10, 6'h11};
        dith = 1'b1; temp = 1'b1; ustr = 1'b1; pixel = 1'b1;
        de = 1'b1; hs = 1'b1; vs = 1'b1;
        r = 8'hAA; g = 8'h55; b = 8'hFF;
        model_reset();
        #3;
        do_reset();

        // Truncation straight after reset, with 2-clock latency
        dith = 1'b0; temp = 1'b0; ustr = 1'b0; pixel = 1'b0;
        de = 1'b1; r = 8'h80; g = 8'h00; b = 8'h00;
        step();
        chk("de_lat1", 24'(vif6.de_out), 24'h0);
        step();
        chk("trunc80", 24'(vif6.r_out), 24'h20);
        chk("de_lat2", 24'(vif6.de_out), 24'h1);
        de = 1'b0;
        step();
        step();

        // Saturation: full-scale input with dither on
        dith = 1'b1; r = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            de = (i < 8);
            step();
            if (i >= 1 && i <= 8) chk("sat", 24'(vif6.r_out), 24'h3F);
        end

        // Ordered pattern on row 0
        r = 8'h00; b = 8'h00;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            g  = (i < 4) ? 8'h41 : 8'h42;
            de = (i < 8);
            step();
            if (i >= 1 && i <= 8) chk("ordered", 24'(vif6.g_out), 24'(gexp[i-1]));
        end

        // Strobe gating on row 1 (thresholds 3,1,3,1 for 6 bits)
        ustr = 1'b1; g = 8'h42;
        for (int i = 0; i < 20; i++) begin
            de    = (i < 16);
            pixel = (i % 4 == 3);
            step();
            if (i >= 1 && i <= 16)
                chk("strobe", 24'(vif6.g_out), (((i - 1) / 4) % 2 == 0) ? 24'h11 : 24'h10);
        end
        ustr = 1'b0; pixel = 1'b0;

        // Five lines; vsync rise coincides with the last DE fall
        do_reset();
        dith = 1'b1; temp = 1'b0; g = 8'h42;
        for (int l = 0; l < 5; l++) begin
            de = 1'b1;
            repeat (4) step();
            de = 1'b0;
            if (l == 4) vs = 1'b1;
            step();
            step();
        end
        step();
        vs = 1'b0;
        step();
        temp = 1'b1; de = 1'b1;
        step();
        de = 1'b0;
        step();
        chk("temporal", 24'(vif6.g_out), 24'h11);
        temp = 1'b0;

        // Truncation to 4 bits
        dith = 1'b0; b = 8'h9F; de = 1'b1;
        step();
        step();
        chk("trunc4", 24'(vif4.b_out), 24'h9);
        chk("trunc6", 24'(vif6.b_out), 24'h27);

        // Reset in the middle of an active line
        dith = 1'b1;
        repeat (3) step();
        do_reset();
        repeat (6) step();

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(7) == 0) de = ~de;
            if ($urandom_range(63) == 0) vs = ~vs;
            hs    = ($urandom_range(15) == 0);
            pixel = $urandom_range(1);
            r = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
            g = 8'($urandom);
            b = ($urandom_range(7) == 0) ? 8'hFE : 8'($urandom);
            if ($urandom_range(31) == 0) dith = ~dith;
            if ($urandom_range(31) == 0) temp = ~temp;
            if ($urandom_range(31) == 0) ustr = ~ustr;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
